er_irq_dma_gate: RTL

ER_IRQ_DMA_GATE -- requirements
Module: er_irq_dma_gate

---
 rtl/vape_pkg.sv | 22 ++
 rtl/er_range_cmp.sv | 16 +
 rtl/er_irq_dma_gate.sv | 117 +++++++++++
 3 files changed

// File: rtl/vape_pkg.sv
// Shared constants, FSM encoding and helpers for the ER interrupt/DMA gate
// and the execution monitor that reuses the range comparator.
package vape_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [CNT_W-1:0] MAX_DEFER_DEFAULT = 16'd1024;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FORCE = 2'd2
    } gate_state_e;

    // Count value at which a pending HOLD is forced open; 0 and 1 both force
    // on the first pending cycle.
    function automatic logic [CNT_W-1:0] force_threshold(input logic [CNT_W-1:0] max_defer);
        return (max_defer <= CNT_W'(1)) ? '0 : (max_defer - CNT_W'(1));
    endfunction

endpackage

// File: rtl/er_range_cmp.sv
// Inclusive unsigned address-range check; an inverted range (min > max)
// never matches.
module er_range_cmp
    import vape_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ER_min,
    input  logic [ADDR_W-1:0] ER_max,
    output logic              in_ER
);

    always_comb begin
        in_ER = (pc >= ER_min) && (pc <= ER_max);
    end

endmodule

// File: rtl/er_irq_dma_gate.sv
// Masks interrupts and DMA grants while the CPU executes inside the
// executable region, deferring them until exit or a bounded timeout.
module er_irq_dma_gate
    import vape_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_DEFER = MAX_DEFER_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ER_min,
    input  logic [ADDR_W-1:0] ER_max,
    input  logic              irq_in,
    output logic              irq_out,
    input  logic              dma_req,
    output logic              dma_gnt,
    output logic              irq_pending,
    output logic              dma_pending,
    output logic [CNT_W-1:0]  defer_cnt,
    output logic              forced
);

    localparam logic [CNT_W-1:0] FORCE_THR = force_threshold(MAX_DEFER);

    gate_state_e      state_q, state_d;
    logic             irq_pend_q, irq_pend_d;
    logic             dma_pend_q, dma_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             forced_q, forced_d;

    logic in_ER;
    logic gate_closed;
    logic any_pend_q;
    logic force_now;
    logic hold_next;

    er_range_cmp u_range (
        .pc     (pc),
        .ER_min (ER_min),
        .ER_max (ER_max),
        .in_ER  (in_ER)
    );

    assign any_pend_q = irq_pend_q || dma_pend_q;
    assign force_now  = (state_q == ST_HOLD) && in_ER && any_pend_q && (cnt_q == FORCE_THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PASS:  if (in_ER) state_d = ST_HOLD;
            ST_HOLD: begin
                if (!in_ER) begin
                    state_d = ST_PASS;
                end else if (force_now) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: if (!in_ER) state_d = ST_PASS;
            default:  state_d = ST_PASS;
        endcase
    end

    always_comb begin
        gate_closed = in_ER && (state_q != ST_FORCE) && !rst;
        irq_out     = irq_in  && !gate_closed && !rst;
        dma_gnt     = dma_req && !gate_closed && !rst;
    end

    // Pending flags also latch in the PASS cycle that enters ER, since the
    // gate is already closed there and the request must not be lost.
    always_comb begin
        hold_next  = (state_d == ST_HOLD);
        irq_pend_d = hold_next && (irq_pend_q || irq_in);
        dma_pend_d = hold_next && (dma_pend_q || dma_req);

        cnt_d = '0;
        if (hold_next) begin
            cnt_d = (any_pend_q && (cnt_q != '1)) ? (cnt_q + CNT_W'(1)) : cnt_q;
        end

        forced_d = forced_q;
        if (force_now) begin
            forced_d = 1'b1;
        end else if ((state_q == ST_PASS) && (pc == ER_min)) begin
            forced_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pend_q <= 1'b0;
            dma_pend_q <= 1'b0;
            cnt_q      <= '0;
            forced_q   <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            dma_pend_q <= dma_pend_d;
            cnt_q      <= cnt_d;
            forced_q   <= forced_d;
        end
    end

    assign irq_pending = irq_pend_q;
    assign dma_pending = dma_pend_q;
    assign defer_cnt   = cnt_q;
    assign forced      = forced_q;

endmodule
